// File: rtl/tag_array_assoc_pkg.sv
// Shared memory-subsystem parameters and the enums used by the set-associative tag array.
package memory_sub_system_param;

    localparam int unsigned INDEX_LENGTH = 4;
    localparam int unsigned TAG_LENGTH   = 8;
    localparam int unsigned WAYS         = 4;

    typedef enum logic [1:0] {
        OpLookup     = 2'd0,
        OpFill       = 2'd1,
        OpMarkDirty  = 2'd2,
        OpInvalidate = 2'd3
    } tag_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPend  = 2'd1,
        StSweep = 2'd2
    } tag_flush_state_t;

endpackage

// File: rtl/tag_array_assoc_way_select.sv
// Combinational way selection: hit detection plus victim choice (lowest invalid way, else rr_ptr).
module tag_way_select #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  match,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way
);

    always_comb begin
        hit        = |(valid & match);
        hit_way    = '0;
        victim_way = rr_ptr;
        // Descending scan so the lowest qualifying way is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[w] && match[w]) hit_way = WAY_W'(w);
            if (!valid[w]) victim_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/tag_array_assoc.sv
// Set-associative tag array with per-way valid/dirty, round-robin replacement and a flush sweep.
module tag_array_assoc
    import memory_sub_system_param::*;
#(
    parameter int unsigned WAYS         = memory_sub_system_param::WAYS,
    parameter int unsigned INDEX_LENGTH = memory_sub_system_param::INDEX_LENGTH,
    parameter int unsigned TAG_LENGTH   = memory_sub_system_param::TAG_LENGTH,
    parameter int unsigned WAY_W        = $clog2(WAYS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  tag_op_t                 req_op,
    input  logic [INDEX_LENGTH-1:0] req_index,
    input  logic [TAG_LENGTH-1:0]   req_tag,
    input  logic [WAY_W-1:0]        req_way,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [WAY_W-1:0]        resp_way,
    output logic [TAG_LENGTH-1:0]   resp_tag,
    output logic                    resp_line_valid,
    output logic                    resp_dirty,
    input  logic                    flush_req,
    output logic                    flush_busy,
    output logic                    flush_done
);

    localparam int unsigned SETS = 2 ** INDEX_LENGTH;

    logic [TAG_LENGTH-1:0]         tag_q [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAY_W-1:0]    rr_q, rr_d;

    tag_flush_state_t              state_q, state_d;
    logic [INDEX_LENGTH-1:0]       sweep_q, sweep_d;
    logic                          done_d, flush_done_q;

    logic                          accept;
    logic [WAYS-1:0]               match;
    logic                          sel_hit;
    logic [WAY_W-1:0]              sel_hit_way, sel_victim_way;
    logic [WAY_W-1:0]              resp_way_d;

    logic                          resp_valid_q, resp_hit_q, resp_line_valid_q, resp_dirty_q;
    logic [WAY_W-1:0]              resp_way_q;
    logic [TAG_LENGTH-1:0]         resp_tag_q;

    assign req_ready  = (state_q == StIdle) && !flush_req;
    assign accept     = req_valid && req_ready;
    assign flush_busy = (state_q != StIdle);
    assign flush_done = flush_done_q;

    always_comb begin
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = (tag_q[req_index][w] == req_tag);
        end
    end

    tag_way_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_way_select (
        .valid      (valid_q[req_index]),
        .match      (match),
        .rr_ptr     (rr_q[req_index]),
        .hit        (sel_hit),
        .hit_way    (sel_hit_way),
        .victim_way (sel_victim_way)
    );

    assign resp_way_d = (req_op == OpLookup) ? (sel_hit ? sel_hit_way : sel_victim_way) : req_way;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: if (flush_req) state_d = StPend;
            StPend: begin
                state_d = StSweep;
                sweep_d = '0;
            end
            StSweep: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == INDEX_LENGTH'(SETS - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        rr_d    = rr_q;
        if (state_q == StSweep) begin
            valid_d[sweep_q] = '0;
            dirty_d[sweep_q] = '0;
        end else if (accept) begin
            unique case (req_op)
                OpLookup: ;
                OpFill: begin
                    valid_d[req_index][req_way] = 1'b1;
                    dirty_d[req_index][req_way] = 1'b0;
                    rr_d[req_index]             = req_way + WAY_W'(1);
                end
                OpMarkDirty: begin
                    if (valid_q[req_index][req_way]) dirty_d[req_index][req_way] = 1'b1;
                end
                OpInvalidate: begin
                    valid_d[req_index][req_way] = 1'b0;
                    dirty_d[req_index][req_way] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            sweep_q      <= '0;
            flush_done_q <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            flush_done_q <= done_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
        end
    end

    // Tags carry no reset; valid bits alone decide whether a tag means anything.
    always_ff @(posedge clk) begin
        if (accept && req_op == OpFill) tag_q[req_index][req_way] <= req_tag;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q      <= 1'b0;
            resp_hit_q        <= 1'b0;
            resp_way_q        <= '0;
            resp_tag_q        <= '0;
            resp_line_valid_q <= 1'b0;
            resp_dirty_q      <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                resp_hit_q        <= (req_op == OpLookup) && sel_hit;
                resp_way_q        <= resp_way_d;
                resp_tag_q        <= tag_q[req_index][resp_way_d];
                resp_line_valid_q <= valid_q[req_index][resp_way_d];
                resp_dirty_q      <= dirty_q[req_index][resp_way_d];
            end
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_hit        = resp_hit_q;
    assign resp_way        = resp_way_q;
    assign resp_tag        = resp_tag_q;
    assign resp_line_valid = resp_line_valid_q;
    assign resp_dirty      = resp_dirty_q;

    always @(posedge clk) begin
        if (resetn && accept && req_op == OpLookup) begin
            assert ($onehot0(valid_q[req_index] & match))
            else $error("tag_array_assoc: multi-way hit in set %0d", req_index);
        end
    end

endmodule

// File: tb/tb_tag_array_assoc.sv
// Directed self-checking bench for tag_array_assoc (WAYS=4, INDEX_LENGTH=4, TAG_LENGTH=8).
module tb_tag_array_assoc;
    import memory_sub_system_param::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    tag_op_t     req_op;
    logic [3:0]  req_index;
    logic [7:0]  req_tag;
    logic [1:0]  req_way;
    logic        resp_valid, resp_hit, resp_line_valid, resp_dirty;
    logic [1:0]  resp_way;
    logic [7:0]  resp_tag;
    logic        flush_req, flush_busy, flush_done;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc;
    int busy_cnt;

    always #5 clk = ~clk;

    tag_array_assoc #(
        .WAYS         (4),
        .INDEX_LENGTH (4),
        .TAG_LENGTH   (8)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .req_way         (req_way),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_tag        (resp_tag),
        .resp_line_valid (resp_line_valid),
        .resp_dirty      (resp_dirty),
        .flush_req       (flush_req),
        .flush_busy      (flush_busy),
        .flush_done      (flush_done)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic do_op(input tag_op_t op, input int idx, input int tg, input int wy);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_index = 4'(idx);
        req_tag   = 8'(tg);
        req_way   = 2'(wy);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_resp(input string name, input int hit, input int way,
                              input int lv, input int dirty);
        check({name, ".valid"}, resp_valid, 1);
        check({name, ".hit"}, resp_hit, hit);
        check({name, ".way"}, resp_way, way);
        check({name, ".line_valid"}, resp_line_valid, lv);
        check({name, ".dirty"}, resp_dirty, dirty);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = OpLookup;
        req_index = '0;
        req_tag   = '0;
        req_way   = '0;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst.ready", req_ready, 1);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.resp_way", resp_way, 0);
        check("rst.resp_tag", resp_tag, 0);
        check("rst.flush_busy", flush_busy, 0);
        check("rst.flush_done", flush_done, 0);

        do_op(OpLookup, 3, 8'h5A, 0);
        check_resp("cold_lookup", 0, 0, 0, 0);

        for (int w = 0; w < 4; w++) do_op(OpFill, 3, 8'h10 + w, w);
        do_op(OpLookup, 3, 8'h12, 0);
        check_resp("hit_w2", 1, 2, 1, 0);
        check("hit_w2.tag", resp_tag, 8'h12);
        do_op(OpMarkDirty, 3, 0, 2);
        check_resp("mark_dirty", 0, 2, 1, 0);
        do_op(OpLookup, 3, 8'h12, 0);
        check_resp("hit_w2_dirty", 1, 2, 1, 1);

        do_op(OpLookup, 3, 8'h77, 0);
        check_resp("miss_rr0", 0, 0, 1, 0);
        do_op(OpFill, 3, 8'h77, 0);
        check_resp("fill_w0", 0, 0, 1, 0);
        check("fill_w0.tag", resp_tag, 8'h10);
        do_op(OpLookup, 3, 8'h99, 0);
        check_resp("miss_rr1", 0, 1, 1, 0);
        check("miss_rr1.tag", resp_tag, 8'h11);
        @(posedge clk);
        #1;
        check("hold.resp_valid", resp_valid, 0);
        check("hold.resp_way", resp_way, 1);
        check("hold.resp_tag", resp_tag, 8'h11);

        do_op(OpInvalidate, 3, 0, 1);
        check_resp("inval_w1", 0, 1, 1, 0);
        do_op(OpFill, 3, 8'h22, 2);
        check_resp("evict_dirty", 0, 2, 1, 1);
        check("evict_dirty.tag", resp_tag, 8'h12);
        do_op(OpLookup, 3, 8'h55, 0);
        check_resp("miss_lowest_invalid", 0, 1, 0, 0);

        // Back-to-back on one set: the lookup must see the fill accepted one cycle earlier.
        @(negedge clk);
        req_valid = 1'b1; req_op = OpFill; req_index = 4'd9; req_tag = 8'hAB; req_way = 2'd0;
        @(negedge clk);
        check("b2b.fill_resp_valid", resp_valid, 1);
        check("b2b.fill_line_valid", resp_line_valid, 0);
        req_op = OpLookup;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_resp("b2b.lookup", 1, 0, 1, 0);

        @(negedge clk);
        flush_req = 1'b1;
        req_valid = 1'b1; req_op = OpLookup; req_index = 4'd3; req_tag = 8'h77;
        #1;
        check("flush.ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        req_valid = 1'b0;
        check("flush.no_accept", resp_valid, 0);
        cyc      = 1;
        busy_cnt = 0;
        while (cyc < 40 && !flush_done) begin
            if (flush_busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("flush.done_cycle", cyc, 18);
        check("flush.busy_cycles", busy_cnt, 17);
        check("flush.busy_after", flush_busy, 0);
        check("flush.ready_after", req_ready, 1);
        @(posedge clk);
        #1;
        check("flush.done_pulse", flush_done, 0);
        do_op(OpLookup, 3, 8'h77, 0);
        check_resp("post_flush_s3", 0, 0, 0, 0);
        do_op(OpLookup, 9, 8'hAB, 0);
        check_resp("post_flush_s9", 0, 0, 0, 0);

        do_op(OpFill, 12, 8'h42, 2);
        check("fill_s12.way", resp_way, 2);
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("abort.flush_busy", flush_busy, 0);
        check("abort.ready", req_ready, 1);
        check("abort.resp_way", resp_way, 0);
        check("abort.flush_done", flush_done, 0);
        @(negedge clk);
        resetn = 1'b1;
        do_op(OpLookup, 12, 8'h42, 0);
        check_resp("abort.lookup_s12", 0, 0, 0, 0);
        check("abort.no_done", flush_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
